// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter and receiver.
//   PAR_*          cfg_parity encodings (2'b11 behaves as PAR_NONE)
//   *_MIN / *_MAX  legal ranges for DATA_W and OVERSAMPLE
//   tx_state_t     transmitter frame states
//   parity_enabled true when a parity bit follows the data bits
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int DATA_W_MIN     = 5;
   localparam int DATA_W_MAX     = 9;
   localparam int OVERSAMPLE_MIN = 2;
   localparam int OVERSAMPLE_MAX = 64;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts baud ticks and flags the last tick of each bit
// period. Shared by the transmitter and the receiver.
//   clk, rst_n_a  clock and asynchronous active-low reset
//   tick          one-clk-wide baud x OVERSAMPLE enable
//   run           count ticks only while high; counter held at 0 otherwise
//   restart       clears the counter; the tick in this cycle is discarded
//   bit_end       high in the cycle whose tick completes a bit period
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst_n_a,
   input  logic tick,
   input  logic run,
   input  logic restart,
   output logic bit_end
);

   localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   logic [CNT_W-1:0] cnt;
   logic             at_last;

   assign at_last = (cnt == CNT_W'(OVERSAMPLE - 1));
   assign bit_end = run & tick & at_last;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n_a) begin
      if (!rst_n_a) begin
         cnt <= '0;
      end else if (restart || !run) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= at_last ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input.
// Sends start bit, DATA_W data bits LSB first, optional parity bit and one
// or two stop bits; each bit lasts OVERSAMPLE tick pulses.
//   clk, rst_n_a   clock and asynchronous active-low reset
//   tick           baud x OVERSAMPLE clock enable
//   tx_valid       word available on tx_data
//   tx_ready       word accepted when tx_valid & tx_ready at a clk edge
//   tx_data        word to send, LSB first
//   cfg_parity     00 none, 01 even, 10 odd, 11 none (latched per frame)
//   cfg_stop2      1 = two stop bits (latched per frame)
//   tx_break       hold the line low while idle
//   tx_busy        frame in progress
//   tx_done        one-clk pulse when the last stop bit ends
//   tx_out         serial line, idle high
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic              clk,
   input  logic              rst_n_a,
   input  logic              tick,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [1:0]        cfg_parity,
   input  logic              cfg_stop2,
   input  logic              tx_break,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              tx_out
);

   if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
      $error("uart_tx_frame: DATA_W must be within 5..9");
   end
   if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX) begin : g_bad_ovs
      $error("uart_tx_frame: OVERSAMPLE must be within 2..64");
   end

   localparam int IDX_W = $clog2(DATA_W);

   tx_state_t         state;
   logic [DATA_W-1:0] shift;     // shadow copy of the word, shifted right per bit
   logic              par_en;    // shadow: frame carries a parity bit
   logic              par_bit;   // shadow: precomputed parity bit value
   logic              stop2;     // shadow: two stop bits
   logic              stop_idx;  // which stop period is running
   logic [IDX_W-1:0]  bit_idx;
   logic              handshake;
   logic              bit_end;

   // Ready follows tx_break directly so a break raised together with
   // tx_valid can never let a word slip through; state itself is registered.
   assign tx_ready  = (state == IDLE) & ~tx_break;
   assign handshake = tx_valid & tx_ready;

   uart_bit_timer #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_bit_timer (
      .clk    (clk),
      .rst_n_a(rst_n_a),
      .tick   (tick),
      .run    (tx_busy),
      .restart(handshake),
      .bit_end(bit_end)
   );

   always_ff @(posedge clk or negedge rst_n_a) begin
      // NOTE: the shadow datapath is reset along with the control state so a
      // frame abandoned by reset leaves no stale word or settings behind.
      if (!rst_n_a) begin
         state    <= IDLE;
         shift    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop2    <= 1'b0;
         stop_idx <= 1'b0;
         bit_idx  <= '0;
         tx_out   <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               tx_out <= ~tx_break;
               if (handshake) begin
                  shift    <= tx_data;
                  par_en   <= parity_enabled(cfg_parity);
                  par_bit  <= (^tx_data) ^ (cfg_parity == PAR_ODD);
                  stop2    <= cfg_stop2;
                  stop_idx <= 1'b0;
                  bit_idx  <= '0;
                  tx_busy  <= 1'b1;
                  tx_out   <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_out <= shift[0];
                  state  <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == IDX_W'(DATA_W - 1)) begin
                     if (par_en) begin
                        tx_out <= par_bit;
                        state  <= PARITY;
                     end else begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                     end
                  end else begin
                     // shift[1] is the bit that becomes shift[0] after this edge
                     tx_out  <= shift[1];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  tx_out <= 1'b1;
                  state  <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (stop2 && !stop_idx) begin
                     stop_idx <= 1'b1;
                  end else begin
                     tx_out  <= ~tx_break;
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               tx_out  <= 1'b1;
               tx_busy <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized self-checking bench for uart_tx_frame.
// Expected line levels come from a frame model that lists the bits of each
// frame (start, data LSB first, parity, stops); the line is checked on every
// counted tick against bit index = ticks_seen / OVERSAMPLE.
module tb_uart_tx_frame;

   localparam int DATA_W = 8;
   localparam int OS     = 16;

   logic              clk;
   logic              rst_n_a;
   logic              tick;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic [1:0]        cfg_parity;
   logic              cfg_stop2;
   logic              tx_break;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_out;

   int compared   = 0;
   int mismatched = 0;
   int done_cnt   = 0;
   bit exp_q[$];

   uart_tx_frame #(
      .DATA_W    (DATA_W),
      .OVERSAMPLE(OS)
   ) dut (
      .clk       (clk),
      .rst_n_a   (rst_n_a),
      .tick      (tick),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .cfg_parity(cfg_parity),
      .cfg_stop2 (cfg_stop2),
      .tx_break  (tx_break),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .tx_out    (tx_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Random one-clk-wide ticks, never two in a row, changed just after posedge.
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick = tick ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (tx_done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference frame: list of line levels, one entry per bit period.
   task automatic build_frame(input int d, input int p, input bit s2);
      int ones;
      ones = 0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < DATA_W; i++) begin
         exp_q.push_back(((d >> i) & 1) == 1);
         ones += (d >> i) & 1;
      end
      if (p == 1) exp_q.push_back((ones % 2) == 1);
      else if (p == 2) exp_q.push_back((ones % 2) == 0);
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);
   endtask

   // Waits for the frame to start; expects it expect_cyc clk edges from now.
   task automatic wait_start(input int expect_cyc, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_busy !== 1'b1 && n < 64);
      compared++;
      if (tx_busy !== 1'b1 || n != expect_cyc) begin
         mismatched++;
         $display("FAIL %s start: busy=%b after %0d clk, required busy=1 after %0d clk",
                  name, tx_busy, n, expect_cyc);
      end
      compared++;
      if (tx_out !== 1'b0 || tx_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL %s start_line: tx_out=%b tx_ready=%b, required 0 0",
                  name, tx_out, tx_ready);
      end
   endtask

   // Called at the first negedge with tx_busy=1; checks the whole frame in exp_q.
   task automatic check_frame(input string name);
      int n_ticks;
      int k;
      int cyc;
      int limit;
      n_ticks = exp_q.size() * OS;
      k       = 0;
      cyc     = 0;
      limit   = n_ticks * 4 + 64;
      while (k < n_ticks && cyc < limit) begin
         compared++;
         if (tx_busy !== 1'b1 || tx_done !== 1'b0) begin
            mismatched++;
            $display("FAIL %s in_frame tick%0d: busy=%b done=%b, required 1 0",
                     name, k, tx_busy, tx_done);
         end
         if (tick === 1'b1) begin
            compared++;
            if (tx_out !== exp_q[k / OS]) begin
               mismatched++;
               $display("FAIL %s bit%0d tick%0d: tx_out=%b, required %b",
                        name, k / OS, k, tx_out, exp_q[k / OS]);
            end
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      compared++;
      if (k < n_ticks) begin
         mismatched++;
         $display("FAIL %s timeout: %0d ticks seen, required %0d", name, k, n_ticks);
      end
      compared++;
      if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_out !== 1'b1 || tx_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL %s end: done=%b busy=%b out=%b ready=%b, required 1 0 1 1",
                  name, tx_done, tx_busy, tx_out, tx_ready);
      end
   endtask

   task automatic send_frame(input int d, input int p, input bit s2, input string name);
      @(negedge clk);
      tx_data    = DATA_W'(d);
      cfg_parity = 2'(p);
      cfg_stop2  = s2;
      tx_valid   = 1'b1;
      wait_start(1, name);
      tx_valid = 1'b0;
      build_frame(d, p, s2);
      check_frame(name);
   endtask

   task automatic test_reset();
      rst_n_a = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_hold: out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                  tx_out, tx_ready, tx_busy, tx_done);
      end
      rst_n_a = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_release: out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                  tx_out, tx_ready, tx_busy, tx_done);
      end
   endtask

   task automatic test_8n1();
      send_frame(8'hA5, 0, 1'b0, "8N1_A5");
   endtask

   task automatic test_parity();
      send_frame(8'h07, 1, 1'b1, "8E2_07");
      send_frame(8'h07, 2, 1'b0, "8O1_07");
      send_frame(8'h3C, 3, 1'b0, "par11_as_none");
   endtask

   task automatic test_back_to_back();
      int w[3];
      int start_done;
      for (int i = 0; i < 3; i++) w[i] = $urandom_range(0, 255);
      start_done = done_cnt;
      @(negedge clk);
      tx_data    = DATA_W'(w[0]);
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      tx_valid   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         // one idle clk (tx_out=1) at the tx_done cycle, then the next start bit
         wait_start(1, "b2b");
         if (i < 2) tx_data = DATA_W'(w[i + 1]);
         else tx_valid = 1'b0;
         build_frame(w[i], 0, 1'b0);
         check_frame("b2b");
      end
      @(negedge clk);
      compared++;
      if (done_cnt - start_done != 3 || tx_busy !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_done_count: %0d pulses busy=%b, required 3 pulses busy=0",
                  done_cnt - start_done, tx_busy);
      end
   endtask

   task automatic test_config_change();
      int d0;
      int d1;
      d0 = $urandom_range(0, 255);
      d1 = d0 ^ 8'h5A;
      @(negedge clk);
      tx_data    = DATA_W'(d0);
      cfg_parity = 2'b01;
      cfg_stop2  = 1'b0;
      tx_valid   = 1'b1;
      wait_start(1, "cfg_f0");
      tx_data    = DATA_W'(d1);
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b1;
      build_frame(d0, 1, 1'b0);
      check_frame("cfg_f0");
      wait_start(1, "cfg_f1");
      tx_valid = 1'b0;
      build_frame(d1, 0, 1'b1);
      check_frame("cfg_f1");
   endtask

   task automatic test_async_reset();
      int k;
      int cyc;
      int start_done;
      start_done = done_cnt;
      @(negedge clk);
      tx_data    = DATA_W'($urandom_range(0, 255) | 8'h10);
      cfg_parity = 2'b01;
      cfg_stop2  = 1'b1;
      tx_valid   = 1'b1;
      wait_start(1, "arst");
      tx_valid = 1'b0;
      // run into the middle of data bit 4 (bit period 5 of the frame)
      k   = 0;
      cyc = 0;
      while (k < 5 * OS + OS / 2 && cyc < 1000) begin
         if (tick === 1'b1) k++;
         @(negedge clk);
         cyc++;
      end
      #2 rst_n_a = 1'b0;
      #1;
      compared++;
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         mismatched++;
         $display("FAIL arst_immediate: out=%b busy=%b done=%b, required 1 0 0",
                  tx_out, tx_busy, tx_done);
      end
      @(negedge clk);
      #2 rst_n_a = 1'b1;
      for (int i = 0; i < 3 * OS; i++) begin
         @(negedge clk);
         compared++;
         if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            mismatched++;
            $display("FAIL arst_after clk%0d: out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     i, tx_out, tx_ready, tx_busy, tx_done);
         end
      end
      compared++;
      if (done_cnt != start_done) begin
         mismatched++;
         $display("FAIL arst_no_done: %0d done pulses, required 0", done_cnt - start_done);
      end
   endtask

   task automatic test_break();
      int d;
      d = $urandom_range(0, 255);
      @(negedge clk);
      tx_break   = 1'b1;
      tx_valid   = 1'b1;
      tx_data    = DATA_W'(d);
      cfg_parity = 2'b10;
      cfg_stop2  = 1'b0;
      #1;
      compared++;
      if (tx_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL break_ready: tx_ready=%b, required 0", tx_ready);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         compared++;
         if (tx_out !== 1'b0 || tx_busy !== 1'b0 || tx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL break_hold clk%0d: out=%b busy=%b ready=%b, required 0 0 0",
                     i, tx_out, tx_busy, tx_ready);
         end
      end
      tx_break = 1'b0;
      #1;
      compared++;
      if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
         mismatched++;
         $display("FAIL break_release: ready=%b busy=%b, required 1 0", tx_ready, tx_busy);
      end
      wait_start(1, "break_send");
      tx_valid = 1'b0;
      build_frame(d, 2, 1'b0);
      check_frame("break_send");
   endtask

   task automatic test_random();
      int d;
      int p;
      bit s2;
      for (int n = 0; n < 6; n++) begin
         d  = $urandom_range(0, 255);
         p  = $urandom_range(0, 3);
         s2 = ($urandom_range(0, 1) == 1);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send_frame(d, p, s2, "random");
      end
   endtask

   initial begin
      rst_n_a    = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = '0;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      tx_break   = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_config_change();
      test_async_reset();
      test_break();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
